// File: rtl/prime_pkg.sv
// Shared types and constants for the prime sweeper.
// Optional build macro: PRIME_SWEEP_SKIP_EVEN_EN.
package prime_pkg;

    localparam int WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/prime_sweeper_if.sv
// Result stream: valid/ready handshake carrying one prime per beat.
// Master drives valid/data, slave drives ready.
interface prime_sweeper_if #(
    parameter int W = 5
) ();

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/prime_flag_comb.sv
// Combinational primality flag by trial division.
// 0 and 1 report non-prime.
module prime_flag_comb
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] n_i,
    output logic             is_prime_o
);

    int n;

    always_comb begin
        n          = int'(n_i);
        is_prime_o = (n >= 2);
        for (int d = 2; d < (1 << WIDTH); d++) begin
            if ((d * d <= n) && (n % d == 0)) begin
                is_prime_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prime_sweeper.sv
// Sweeps lo..hi, pushes primes into a FIFO and streams them out.
// Build with PRIME_SWEEP_SKIP_EVEN_EN to skip even candidates above 2.
module prime_sweeper
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           lo,
    input  logic [WIDTH-1:0]           hi,
    output logic                       busy,
    output logic                       done,
    output logic [cnt_w(WIDTH)-1:0]    prime_count,
    prime_sweeper_if.master            res
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int PCW  = cnt_w(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   cand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [PCW-1:0]     pc_q;
    logic               done_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      rd_q;
    logic [AW-1:0]      wr_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [WIDTH-1:0]   head_q;
    logic [WIDTH-1:0]   head_d;

    logic               is_p;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               advance;
    logic               last;
    logic [WIDTH-1:0]   cand_nx;

    prime_flag_comb #(
        .WIDTH (WIDTH)
    ) u_flag (
        .n_i        (cand_q),
        .is_prime_o (is_p)
    );

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop     = !empty && res.out_ready;
    assign push    = (state_q == SCAN) && is_p && (!full || pop);
    assign advance = (state_q == SCAN) && (!is_p || push);
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

`ifdef PRIME_SWEEP_SKIP_EVEN_EN
    logic [WIDTH:0] nxt_w;
    assign nxt_w   = {1'b0, cand_q}
                   + (((cand_q < WIDTH'(2)) || !cand_q[0])
                      ? (WIDTH+1)'(1) : (WIDTH+1)'(2));
    assign last    = (nxt_w > {1'b0, hi_q});
    assign cand_nx = nxt_w[WIDTH-1:0];
`else
    assign last    = (cand_q == hi_q);
    assign cand_nx = cand_q + WIDTH'(1);
`endif

    // Head register tracks whatever entry will sit at rd after this edge.
    always_comb begin
        head_d = head_q;
        if (pop && (cnt_q > CW'(1))) begin
            head_d = mem_q[rd_q + AW'(1)];
        end else if (push && (empty || pop)) begin
            head_d = cand_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            hi_q    <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            if (push) begin
                mem_q[wr_q] <= cand_q;
                wr_q        <= wr_q + AW'(1);
                pc_q        <= pc_q + PCW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cand_q  <= lo;
                        hi_q    <= hi;
                        pc_q    <= '0;
                        state_q <= (lo > hi) ? DRAIN : SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (last) begin
                            state_q <= DRAIN;
                        end else begin
                            cand_q <= cand_nx;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == '0) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q == SCAN) || (state_q == DRAIN);
    assign done          = done_q;
    assign prime_count   = pc_q;
    assign res.out_valid = !empty;
    assign res.out_data  = head_q;

endmodule
